// File: rtl/kgp_pkg.sv
// Shared definitions for the KGPminiRISC fetch stage: FSM state encoding,
// the halt opcode and the default reset-PC / increment values.
package kgp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_PC = 3'd3,
    ST_HALT    = 3'd4
  } fetch_state_t;

  // All-ones word is reserved as the halt instruction.
  localparam logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF;

  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  // Instruction memory is word-addressed, so the sequential step is one.
  localparam logic [31:0] DEF_PC_INC   = 32'd1;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage of the KGPminiRISC core.
// Holds the architectural PC, fetches one instruction over imem req/ack,
// presents it to decode over valid/ready, then waits for the resolved
// next PC from execute. At most one instruction is in flight.
// Optional feature macro: FETCH_HALT_EN (stop fetching on HALT_INSTR).
module fetch_pc_unit
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus,
  input  logic [31:0] pc_next,
  input  logic        pc_valid,
  output logic        halted
);

  fetch_state_t state_r;
  fetch_state_t state_s;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic         imem_req_r;
  logic         instr_valid_r;
  logic         halt_hit_s;

`ifdef FETCH_HALT_EN
  logic         halted_r;

  assign halt_hit_s = (instr_r == HALT_INSTR);
`else
  assign halt_hit_s = 1'b0;
`endif

  // Next-state logic; stray handshakes outside their own state are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          if (halt_hit_s) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_WAIT_PC;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_PC: begin
        if (pc_valid) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_WAIT_PC;
        end
      end
      ST_HALT: begin
`ifdef FETCH_HALT_EN
        state_s = ST_HALT;
`else
        state_s = ST_IDLE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered decodes of the upcoming state so the
  // handshake outputs carry no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      imem_req_r    <= (state_s == ST_FETCH);
      instr_valid_r <= (state_s == ST_ISSUE);
    end
  end

`ifdef FETCH_HALT_EN
  // Halt flag, set on entry to HALT; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_s == ST_HALT);
    end
  end

  assign halted = halted_r;
`else
  assign halted = 1'b0;
`endif

  // PC loads the resolved target only when execute completes in WAIT_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if ((state_r == ST_WAIT_PC) && pc_valid) begin
      pc_r <= pc_next;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction capture on the memory acknowledge while fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= 32'd0;
    end else if ((state_r == ST_FETCH) && imem_ack) begin
      instr_r <= imem_rdata;
    end else begin
      instr_r <= instr_r;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  // Sequential successor; wraps modulo 2^32 with no carry flag.
  assign pc_plus     = pc_r + PC_INC;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. A reference model tracks the
// architectural PC, the last fetched word and the halt condition; random
// memory latency, decode backpressure and jump targets are applied.
module tb_fetch_pc_unit;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] pc_next = 32'd0;
  logic        pc_valid = 1'b0;
  logic        halted;

  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] model_pc;
  logic [31:0] model_word;
  logic        model_halted;

  fetch_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus     (pc_plus),
    .pc_next     (pc_next),
    .pc_valid    (pc_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_WORD) w = 32'h0BAD_F00D;
    return w;
  endfunction

  // Memory answers after 'waits' idle request cycles; request/address must hold.
  task automatic fetch_word(input int waits, input logic [31:0] word);
    for (int i = 0; i <= waits; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_hold cyc%0d: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 i, imem_req, imem_addr, instr_valid, model_pc);
      end
      if (i == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = word;
      end
      tick();
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    model_word = word;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== word || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_capture: valid=%b instr=%h req=%b, required valid=1 instr=%h req=0",
               instr_valid, instr, imem_req, word);
    end
  endtask

  // Decode holds off for 'delay' cycles while stray ack/pc_valid pulses arrive.
  task automatic accept(input int delay);
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      pc_valid   = 1'($urandom);
      pc_next    = $urandom;
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== model_word || pc !== model_pc || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL issue_stall cyc%0d: valid=%b instr=%h pc=%h req=%b, required valid=1 instr=%h pc=%h req=0",
                 i, instr_valid, instr, pc, imem_req, model_word, model_pc);
      end
    end
    imem_ack    = 1'b0;
    pc_valid    = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready  = 1'b0;
    model_halted = HALT_EN && (model_word == HALT_WORD);
    n_checks++;
    if (instr_valid !== 1'b0 || halted !== model_halted || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_accept: valid=%b halted=%b req=%b, required valid=0 halted=%b req=0",
               instr_valid, halted, imem_req, model_halted);
    end
  endtask

  // Execute finishes after 'delay' cycles with target 'target'.
  task automatic resolve(input int delay, input logic [31:0] target);
    for (int i = 0; i < delay; i++) begin
      imem_ack    = 1'($urandom);
      instr_ready = 1'($urandom);
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== model_pc) begin
        n_fail++;
        $display("FAIL wait_pc cyc%0d: req=%b valid=%b pc=%h, required req=0 valid=0 pc=%h",
                 i, imem_req, instr_valid, pc, model_pc);
      end
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    pc_valid    = 1'b1;
    pc_next     = target;
    tick();
    pc_valid = 1'b0;
    pc_next  = $urandom;
    model_pc = target;
    n_checks++;
    if (pc !== model_pc || imem_addr !== model_pc || imem_req !== 1'b1 || pc_plus !== model_pc + 32'd1) begin
      n_fail++;
      $display("FAIL pc_load: pc=%h addr=%h req=%b pc_plus=%h, required pc=addr=%h req=1 pc_plus=%h",
               pc, imem_addr, imem_req, pc_plus, model_pc, model_pc + 32'd1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (pc !== 32'd0 || pc_plus !== 32'd1 || instr !== 32'd0 || imem_req !== 1'b0 ||
        instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h pc_plus=%h instr=%h req=%b valid=%b halted=%b, required 0/1/0/0/0/0",
               pc, pc_plus, instr, imem_req, instr_valid, halted);
    end
    rst_n    = 1'b1;     // released at edge 0
    model_pc = 32'd0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: req=%b, required 0", imem_req);
    end
    tick();              // edge 1
    fetch_word(0, 32'h1234_5678);
  endtask

  task automatic test_sequential();
    accept(0);
    while (model_pc != 32'd4) begin
      resolve(0, model_pc + 32'd1);
      fetch_word(0, rand_word());
      accept(0);
    end
    resolve(0, 32'd5);
    n_checks++;
    if (pc !== 32'd5 || pc_plus !== 32'd6) begin
      n_fail++;
      $display("FAIL seq_pc5: pc=%h pc_plus=%h, required 5 and 6", pc, pc_plus);
    end
    fetch_word(0, rand_word());
    accept(0);
    resolve(1, 32'd6);
  endtask

  task automatic test_jump_wait();
    fetch_word(0, rand_word());
    accept(0);
    resolve(2, 32'd10);
    fetch_word(3, rand_word());
  endtask

  task automatic test_backpressure();
    accept(5);
  endtask

  task automatic test_wrap();
    resolve(0, 32'hFFFF_FFFF);
    n_checks++;
    if (pc_plus !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap: pc_plus=%h, required 00000000", pc_plus);
    end
    fetch_word(1, rand_word());
    accept(0);
    resolve(0, 32'd100);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      fetch_word($urandom_range(0, 3), rand_word());
      accept($urandom_range(0, 3));
      resolve($urandom_range(0, 3), $urandom);
    end
  endtask

  task automatic test_halt();
    fetch_word(0, HALT_WORD);
    accept(0);
    if (HALT_EN) begin
      for (int i = 0; i < 5; i++) begin
        imem_ack    = 1'($urandom);
        instr_ready = 1'($urandom);
        pc_valid    = 1'($urandom);
        pc_next     = $urandom;
        tick();
        n_checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== model_pc) begin
          n_fail++;
          $display("FAIL halt_hold cyc%0d: halted=%b req=%b valid=%b pc=%h, required 1/0/0 pc=%h",
                   i, halted, imem_req, instr_valid, pc, model_pc);
        end
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      pc_valid    = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      model_pc = 32'd0;
      tick();
    end else begin
      resolve(0, 32'd7);
    end
  endtask

  task automatic test_reset_midfetch();
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midfetch_pre: req=%b, required 1", imem_req);
    end
    tick();
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (pc !== 32'd0 || instr !== 32'd0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL midfetch_reset: pc=%h instr=%h req=%b valid=%b halted=%b, required all 0",
               pc, instr, imem_req, instr_valid, halted);
    end
    tick();
    rst_n    = 1'b1;     // edge 0
    model_pc = 32'd0;
    tick();              // edge 1 samples the late ack in IDLE
    imem_ack = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'd0) begin
      n_fail++;
      $display("FAIL late_ack: req=%b valid=%b instr=%h, required req=1 valid=0 instr=0",
               imem_req, instr_valid, instr);
    end
    tick();
    fetch_word(0, 32'hCAFE_0001);
    accept(1);
  endtask

  initial begin
    model_pc     = 32'd0;
    model_word   = 32'd0;
    model_halted = 1'b0;
    test_reset();
    test_sequential();
    test_jump_wait();
    test_backpressure();
    test_wrap();
    test_random();
    test_halt();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
